// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader: instruction field positions,
// FSM state encodings and error codes.
package instruction_loader_pkg;

    localparam int unsigned COND_HI = 31;
    localparam int unsigned COND_LO = 28;
    localparam int unsigned OP_HI   = 27;
    localparam int unsigned OP_LO   = 24;
    localparam int unsigned S_BIT   = 23;
    localparam int unsigned DST_HI  = 22;
    localparam int unsigned DST_LO  = 19;
    localparam int unsigned SRC2_HI = 18;
    localparam int unsigned SRC2_LO = 15;
    localparam int unsigned SRC1_HI = 14;
    localparam int unsigned SRC1_LO = 11;
    localparam int unsigned SH_HI   = 10;
    localparam int unsigned SH_LO   = 6;
    localparam int unsigned MOV_HI  = 18;
    localparam int unsigned MOV_LO  = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        WRITE    = 3'd2,
        READBACK = 3'd3,
        DONE     = 3'd4,
        ERROR    = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_VERIFY = 2'b01;
    localparam logic [1:0] ERR_RANGE  = 2'b10;

endpackage

// File: rtl/instruction_loader_encoder.sv
// Combinational packer from decoded instruction fields to the 32-bit word
// that the fetch stage splits apart again.
module instr_encoder
    import instruction_loader_pkg::*;
(
    input  logic        Mov_fmt,
    input  logic [3:0]  Cond,
    input  logic [3:0]  OpCode,
    input  logic        S,
    input  logic [3:0]  destination,
    input  logic [3:0]  source_2,
    input  logic [3:0]  source_1,
    input  logic [4:0]  IV_ShiftRor,
    input  logic [15:0] IV_Mov,
    output logic [31:0] Word
);

    always_comb begin
        Word                   = '0;
        Word[COND_HI:COND_LO]  = Cond;
        Word[OP_HI:OP_LO]      = OpCode;
        Word[S_BIT]            = S;
        Word[DST_HI:DST_LO]    = destination;
        if (Mov_fmt) begin
            Word[MOV_HI:MOV_LO] = IV_Mov;
        end else begin
            Word[SRC2_HI:SRC2_LO] = source_2;
            Word[SRC1_HI:SRC1_LO] = source_1;
            Word[SH_HI:SH_LO]     = IV_ShiftRor;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Run-time program loader: accepts instruction fields, packs them, writes each
// word to consecutive RAM locations and reads it back to verify.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Base_addr,
    input  logic [ADDR_W-1:0] Count,
    input  logic              In_valid,
    output logic              In_ready,
    input  logic              Mov_fmt,
    input  logic [3:0]        Cond,
    input  logic [3:0]        OpCode,
    input  logic              S,
    input  logic [3:0]        destination,
    input  logic [3:0]        source_2,
    input  logic [3:0]        source_1,
    input  logic [4:0]        IV_ShiftRor,
    input  logic [15:0]       IV_Mov,
    output logic              Enable,
    output logic              RW_ram,
    output logic [ADDR_W-1:0] Address,
    output logic [31:0]       In,
    input  logic [31:0]       Out,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic [1:0]        Err_code,
    output logic [ADDR_W-1:0] Words_loaded
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_remaining;
    logic [31:0]       r_word;
    logic [31:0]       w_word;
    logic [ADDR_W:0]   w_end_addr;
    logic              w_range_ovf;

    instr_encoder u_encoder (
        .Mov_fmt    (Mov_fmt),
        .Cond       (Cond),
        .OpCode     (OpCode),
        .S          (S),
        .destination(destination),
        .source_2   (source_2),
        .source_1   (source_1),
        .IV_ShiftRor(IV_ShiftRor),
        .IV_Mov     (IV_Mov),
        .Word       (w_word)
    );

    // One extra bit so Base_addr+Count cannot wrap before the range check.
    assign w_end_addr  = {1'b0, Base_addr} + {1'b0, Count};
    assign w_range_ovf = w_end_addr > (ADDR_W+1)'(DEPTH);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_remaining  <= '0;
            r_word       <= '0;
            In_ready     <= 1'b0;
            Enable       <= 1'b0;
            RW_ram       <= 1'b1;
            Address      <= '0;
            In           <= '0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            Error        <= 1'b0;
            Err_code     <= ERR_NONE;
            Words_loaded <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_ptr        <= Base_addr;
                        r_remaining  <= Count;
                        Error        <= 1'b0;
                        Err_code     <= ERR_NONE;
                        Words_loaded <= '0;
                        Busy         <= 1'b1;
                        if (Count == '0) begin
                            r_state <= DONE;
                            Done    <= 1'b1;
                        end else if (w_range_ovf) begin
                            r_state  <= ERROR;
                            Error    <= 1'b1;
                            Err_code <= ERR_RANGE;
                        end else begin
                            r_state  <= LOAD;
                            In_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (In_valid) begin
                        r_state  <= WRITE;
                        r_word   <= w_word;
                        In_ready <= 1'b0;
                        Enable   <= 1'b1;
                        RW_ram   <= 1'b0;
                        Address  <= r_ptr;
                        In       <= w_word;
                    end
                end
                WRITE: begin
                    r_state <= READBACK;
                    RW_ram  <= 1'b1;
                    In      <= '0;
                end
                READBACK: begin
                    Enable  <= 1'b0;
                    Address <= '0;
                    if (Out != r_word) begin
                        r_state  <= ERROR;
                        Error    <= 1'b1;
                        Err_code <= ERR_VERIFY;
                    end else begin
                        r_ptr        <= r_ptr + 1'b1;
                        r_remaining  <= r_remaining - 1'b1;
                        Words_loaded <= Words_loaded + 1'b1;
                        if (r_remaining == ADDR_W'(1)) begin
                            r_state <= DONE;
                            Done    <= 1'b1;
                        end else begin
                            r_state  <= LOAD;
                            In_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    Done    <= 1'b0;
                    Busy    <= 1'b0;
                end
                ERROR: begin
                    r_state <= IDLE;
                    Busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed self-checking bench for instruction_loader with a behavioural
// 256-word RAM that can corrupt read data on demand.
module tb_instruction_loader;

    localparam int unsigned ADDR_W = 16;

    logic              clk = 1'b0;
    logic              Reset;
    logic              Start;
    logic [ADDR_W-1:0] Base_addr;
    logic [ADDR_W-1:0] Count;
    logic              In_valid;
    logic              In_ready;
    logic              Mov_fmt;
    logic [3:0]        Cond;
    logic [3:0]        OpCode;
    logic              S;
    logic [3:0]        destination;
    logic [3:0]        source_2;
    logic [3:0]        source_1;
    logic [4:0]        IV_ShiftRor;
    logic [15:0]       IV_Mov;
    logic              Enable;
    logic              RW_ram;
    logic [ADDR_W-1:0] Address;
    logic [31:0]       In;
    logic [31:0]       Out;
    logic              Busy;
    logic              Done;
    logic              Error;
    logic [1:0]        Err_code;
    logic [ADDR_W-1:0] Words_loaded;

    logic [31:0] ram [256];
    logic        flip = 1'b0;
    int          n_writes = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    instruction_loader #(
        .ADDR_W(ADDR_W),
        .DEPTH (256)
    ) dut (
        .Clk         (clk),
        .Reset       (Reset),
        .Start       (Start),
        .Base_addr   (Base_addr),
        .Count       (Count),
        .In_valid    (In_valid),
        .In_ready    (In_ready),
        .Mov_fmt     (Mov_fmt),
        .Cond        (Cond),
        .OpCode      (OpCode),
        .S           (S),
        .destination (destination),
        .source_2    (source_2),
        .source_1    (source_1),
        .IV_ShiftRor (IV_ShiftRor),
        .IV_Mov      (IV_Mov),
        .Enable      (Enable),
        .RW_ram      (RW_ram),
        .Address     (Address),
        .In          (In),
        .Out         (Out),
        .Busy        (Busy),
        .Done        (Done),
        .Error       (Error),
        .Err_code    (Err_code),
        .Words_loaded(Words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (Reset && Enable && !RW_ram) begin
            ram[Address[7:0]] <= In;
            n_writes          <= n_writes + 1;
        end
    end

    assign Out = (Enable && RW_ram) ? (ram[Address[7:0]] ^ {31'b0, flip}) : 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] cnt);
        Start     = 1'b1;
        Base_addr = base;
        Count     = cnt;
        tick();
        Start     = 1'b0;
    endtask

    task automatic set_reg(input logic [3:0] c, input logic [3:0] op, input logic s,
                           input logic [3:0] d, input logic [3:0] s2, input logic [3:0] s1,
                           input logic [4:0] sh);
        Mov_fmt = 1'b0; Cond = c; OpCode = op; S = s; destination = d;
        source_2 = s2; source_1 = s1; IV_ShiftRor = sh; IV_Mov = 16'hFFFF;
    endtask

    task automatic set_mov(input logic [3:0] c, input logic [3:0] op, input logic s,
                           input logic [3:0] d, input logic [15:0] imm);
        Mov_fmt = 1'b1; Cond = c; OpCode = op; S = s; destination = d;
        source_2 = 4'hF; source_1 = 4'hF; IV_ShiftRor = 5'h1F; IV_Mov = imm;
    endtask

    // Present the already-set fields and return once the word is accepted.
    task automatic send_word(input string tag);
        int waited = 0;
        In_valid = 1'b1;
        while (!In_ready && waited < 10) begin
            tick();
            waited++;
        end
        if (!In_ready) begin
            check_eq({tag, "_ready_timeout"}, 32'(In_ready), 32'd1);
        end
        tick();
        In_valid = 1'b0;
    endtask

    initial begin
        int cycles;
        int wr_snap;
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        Reset = 1'b0; Start = 1'b0; Base_addr = '0; Count = '0; In_valid = 1'b0;
        set_reg(4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 5'h0);
        tick();
        tick();
        check_eq("rst_in_ready", 32'(In_ready), 32'd0);
        check_eq("rst_enable", 32'(Enable), 32'd0);
        check_eq("rst_rw", 32'(RW_ram), 32'd1);
        check_eq("rst_addr", 32'(Address), 32'd0);
        check_eq("rst_flags", {27'b0, Busy, Done, Error, Err_code}, 32'd0);
        Reset = 1'b1;
        tick();

        // Register-format word at address 0
        start_session(16'd0, 16'd1);
        check_eq("t1_ready", 32'(In_ready), 32'd1);
        check_eq("t1_busy", 32'(Busy), 32'd1);
        set_reg(4'hE, 4'h1, 1'b1, 4'h5, 4'h2, 4'h3, 5'h4);
        send_word("t1");
        check_eq("t1_wr_ctl", {30'b0, Enable, RW_ram}, 32'h2);
        check_eq("t1_wr_data", In, 32'hE1A91900);
        check_eq("t1_wr_addr", 32'(Address), 32'd0);
        tick();
        check_eq("t1_rd_ctl", {30'b0, Enable, RW_ram}, 32'h3);
        tick();
        check_eq("t1_done", 32'(Done), 32'd1);
        check_eq("t1_words", 32'(Words_loaded), 32'd1);
        check_eq("t1_ram0", ram[0], 32'hE1A91900);
        tick();
        check_eq("t1_done_pulse", {30'b0, Done, Busy}, 32'd0);

        // Move-format word at address 10
        start_session(16'd10, 16'd1);
        set_mov(4'hE, 4'hD, 1'b0, 4'h1, 16'h1234);
        send_word("t2");
        check_eq("t2_wr_data", In, 32'hED0891A0);
        check_eq("t2_wr_addr", 32'(Address), 32'd10);
        tick();
        tick();
        check_eq("t2_done", 32'(Done), 32'd1);
        check_eq("t2_ram10", ram[10], 32'hED0891A0);
        tick();

        // Burst of 4 ending exactly at the top of RAM, In_valid held high
        wr_snap = n_writes;
        set_reg(4'h0, 4'h4, 1'b0, 4'h2, 4'h7, 4'h8, 5'h1F);
        In_valid = 1'b1;
        start_session(16'd252, 16'd4);
        cycles = 0;
        while (!Done && cycles < 40) begin
            tick();
            cycles++;
        end
        In_valid = 1'b0;
        check_eq("t3_done_latency", 32'(cycles), 32'd12);
        check_eq("t3_words", 32'(Words_loaded), 32'd4);
        check_eq("t3_writes", 32'(n_writes - wr_snap), 32'd4);
        for (int a = 252; a < 256; a++) check_eq("t3_ram", ram[a], 32'h0413C7C0);
        check_eq("t3_error", 32'(Error), 32'd0);
        tick();

        // Range overflow
        wr_snap = n_writes;
        start_session(16'd254, 16'd4);
        check_eq("t4_error", 32'(Error), 32'd1);
        check_eq("t4_code", 32'(Err_code), 32'd2);
        check_eq("t4_ready", 32'(In_ready), 32'd0);
        tick();
        check_eq("t4_idle", {30'b0, Busy, Error}, 32'd1);
        tick();
        check_eq("t4_sticky", 32'(Error), 32'd1);
        check_eq("t4_no_write", 32'(n_writes - wr_snap), 32'd0);

        // Verify failure: read data bit 0 corrupted
        start_session(16'd20, 16'd1);
        check_eq("t5_err_clr", {30'b0, Err_code}, 32'd0);
        set_mov(4'h1, 4'h2, 1'b1, 4'h3, 16'hBEEF);
        send_word("t5");
        flip = 1'b1;
        tick();
        tick();
        flip = 1'b0;
        check_eq("t5_error", 32'(Error), 32'd1);
        check_eq("t5_code", 32'(Err_code), 32'd1);
        check_eq("t5_words", 32'(Words_loaded), 32'd0);
        check_eq("t5_no_done", 32'(Done), 32'd0);
        tick();

        // Count of zero
        wr_snap = n_writes;
        start_session(16'd5, 16'd0);
        check_eq("t6_done", 32'(Done), 32'd1);
        check_eq("t6_enable", 32'(Enable), 32'd0);
        check_eq("t6_err_clr", 32'(Error), 32'd0);
        tick();
        check_eq("t6_pulse", {30'b0, Done, Busy}, 32'd0);
        check_eq("t6_no_write", 32'(n_writes - wr_snap), 32'd0);

        // Reset asserted while in WRITE aborts before the write edge
        start_session(16'd30, 16'd1);
        set_reg(4'h9, 4'h9, 1'b1, 4'h9, 4'h9, 4'h9, 5'h9);
        send_word("t7");
        check_eq("t7_in_write", 32'(Enable), 32'd1);
        #1 Reset = 1'b0;
        #1;
        check_eq("t7_rst_ctl", {29'b0, In_ready, Enable, RW_ram}, 32'h1);
        check_eq("t7_rst_addr", 32'(Address), 32'd0);
        check_eq("t7_rst_data", In, 32'd0);
        check_eq("t7_rst_flags", {27'b0, Busy, Done, Error, Err_code}, 32'd0);
        tick();
        check_eq("t7_ram30", ram[30], 32'd0);
        Reset = 1'b1;
        tick();
        check_eq("t7_idle", 32'(Busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Writer-side counterpart to the CPU fetch/decode path.
- Accepts decoded instruction fields over a valid/ready handshake and packs them into the 32-bit instruction word the fetch stage splits apart.
- Writes each word into consecutive program RAM locations, then reads it back to verify it.
- Used to load programs at run time instead of preloading memory.

Parameters:
- ADDR_W, 16, RAM address width.
- DEPTH, 256, number of RAM words available for program storage.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle pulse that begins a load session; honoured only in IDLE.
- Base_addr  input  ADDR_W  first RAM address of the session; latched on Start.
- Count  input  ADDR_W  number of words to load; latched on Start.
- In_valid  input  1  instruction fields are valid.
- In_ready  output  1  loader can accept fields.
- Mov_fmt  input  1  1 = immediate-move format, 0 = register format.
- Cond  input  4  condition field.
- OpCode  input  4  opcode field.
- S  input  1  set-flags bit.
- destination  input  4  destination register.
- source_2  input  4  second source register (register format).
- source_1  input  4  first source register (register format).
- IV_ShiftRor  input  5  shift/rotate amount (register format).
- IV_Mov  input  16  move immediate (move format).
- Enable  output  1  RAM enable.
- RW_ram  output  1  1 = read, 0 = write.
- Address  output  ADDR_W  RAM address.
- In  output  32  RAM write data.
- Out  input  32  RAM read data; combinational while Enable=1 and RW_ram=1.
- Busy  output  1  high in every state except IDLE.
- Done  output  1  one-cycle pulse on successful completion.
- Error  output  1  sticky error flag.
- Err_code  output  2  01 = verify mismatch, 10 = range overflow.
- Words_loaded  output  ADDR_W  number of words verified this session.

Behaviour:
- Encoding, both formats:
  - [31:28] Cond, [27:24] OpCode, [23] S, [22:19] destination.
  - Register format: [18:15] source_2, [14:11] source_1, [10:6] IV_ShiftRor, [5:0] zero.
  - Move format: [18:3] IV_Mov, [2:0] zero.
- Reset (asynchronous, Reset=0):
  - State = IDLE.
  - In_ready=0, Enable=0, RW_ram=1, Address=0, In=0.
  - Busy=0, Done=0, Error=0, Err_code=00, Words_loaded=0.
- IDLE:
  - Outputs as after reset, except Error/Err_code hold their last value.
  - On Start: latch Base_addr into the pointer and Count into the remaining counter; clear Error, Err_code and Words_loaded.
  - Next state: DONE if Count=0; ERROR with code 10 if Base_addr+Count > DEPTH (compute at ADDR_W+1 bits); otherwise LOAD.
- LOAD:
  - In_ready=1.
  - On In_valid&In_ready: register the encoded word and go to WRITE.
  - Otherwise stay; no timeout.
- WRITE (one cycle):
  - Enable=1, RW_ram=0, Address=pointer, In=word.
  - Next state READBACK.
- READBACK (one cycle):
  - Enable=1, RW_ram=1, Address=pointer.
  - Compare Out against the word at the clock edge.
  - Mismatch: go to ERROR, code 01; pointer is not advanced.
  - Match: pointer+1, remaining-1, Words_loaded+1; go to DONE if the new remaining count is 0, else LOAD.
- DONE: Done=1 for exactly one cycle, then IDLE.
- ERROR: Error=1 and Err_code set, then IDLE the next cycle; Error remains asserted until the next accepted Start or reset.
- Throughput: minimum 3 cycles per word (LOAD, WRITE, READBACK).
- Start outside IDLE is ignored.
- In_valid outside LOAD is ignored, and In_ready=0 there.
- Reset asserted mid-session aborts immediately. No partial-word write is issued after reset; any words already written stay in RAM.
- Pointer never wraps; range is checked up front.

Decomposition:
- Shared package holds:
  - Field bit-position constants: COND_HI/LO, OP_HI/LO, S_BIT, DST_HI/LO, SRC2_HI/LO, SRC1_HI/LO, SH_HI/LO, MOV_HI/LO.
  - FSM state encodings: IDLE, LOAD, WRITE, READBACK, DONE, ERROR.
  - Error codes: ERR_VERIFY=2'b01, ERR_RANGE=2'b10.
- One sub-module, instr_encoder: purely combinational field-to-word packer, reusable by the assembler bench.

Test Plan:
- Register-format word: Start with Base_addr=0, Count=1, then fields Cond=E, OpCode=1, S=1, dest=5, src2=2, src1=3, shift=4, Mov_fmt=0 -> RAM[0]=0xE1A91900, Done pulse, Words_loaded=1.
- Move-format word: Cond=E, OpCode=D, S=0, dest=1, IV_Mov=0x1234, Mov_fmt=1, Base_addr=10 -> RAM[10]=0xED0891A0.
- Burst: Count=4, Base_addr=252, In_valid held high -> addresses 252..255 written; Done asserted 12 cycles after the first accept.
- Range overflow: Base_addr=254, Count=4 -> Error=1, Err_code=10, no RAM write.
- Verify failure: force Out bit 0 flipped during READBACK -> Error=1, Err_code=01, Words_loaded unchanged.
- Count=0: Done pulses 1 cycle after Start with no RAM access. Reset pulled low during WRITE -> all outputs return to reset values asynchronously.
